// File: rtl/lru_replacement_algorithm.sv
// True-LRU victim selector for one cache set: per-line age counters forming a
// permutation of 0..N-1, with access (make MRU) and invalidate (make LRU) updates.
module lru_replacement_algorithm #(
    parameter int unsigned NUMBER_OF_CACHE_LINES = 4,
    parameter int unsigned COUNTER_WIDTH = (NUMBER_OF_CACHE_LINES <= 4)  ? 2 :
                                           (NUMBER_OF_CACHE_LINES <= 8)  ? 3 :
                                           (NUMBER_OF_CACHE_LINES <= 16) ? 4 :
                                           (NUMBER_OF_CACHE_LINES <= 32) ? 5 :
                                           (NUMBER_OF_CACHE_LINES <= 64) ? 6 :
                                           (NUMBER_OF_CACHE_LINES <= 128) ? 7 : 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine,
    input  logic                     invalidate,
    input  logic [COUNTER_WIDTH-1:0] invalidatedCacheLine,
    output logic [COUNTER_WIDTH-1:0] replacementCacheLine
);

    localparam logic [COUNTER_WIDTH-1:0] MaxAge = COUNTER_WIDTH'(NUMBER_OF_CACHE_LINES - 1);

    logic [COUNTER_WIDTH-1:0] age     [NUMBER_OF_CACHE_LINES];
    logic [COUNTER_WIDTH-1:0] ageNext [NUMBER_OF_CACHE_LINES];
    logic [COUNTER_WIDTH-1:0] accessAge;
    logic [COUNTER_WIDTH-1:0] invalidAge;
    logic                     accessHit;
    logic                     invalidHit;

    // Index lookup by scan so out-of-range indices (non power-of-two N) simply miss.
    always_comb begin
        accessAge  = '0;
        invalidAge = '0;
        accessHit  = 1'b0;
        invalidHit = 1'b0;
        for (int unsigned i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
            if (COUNTER_WIDTH'(i) == lastAccessedCacheLine) begin
                accessAge = age[i];
                accessHit = 1'b1;
            end
            if (COUNTER_WIDTH'(i) == invalidatedCacheLine) begin
                invalidAge = age[i];
                invalidHit = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
            ageNext[i] = age[i];
        end
        if (invalidate) begin
            if (invalidHit) begin
                for (int unsigned i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
                    if (COUNTER_WIDTH'(i) == invalidatedCacheLine)
                        ageNext[i] = MaxAge;
                    else if (age[i] > invalidAge)
                        ageNext[i] = age[i] - COUNTER_WIDTH'(1);
                end
            end
        end else if (enable && accessHit) begin
            for (int unsigned i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
                if (COUNTER_WIDTH'(i) == lastAccessedCacheLine)
                    ageNext[i] = '0;
                else if (age[i] < accessAge)
                    ageNext[i] = age[i] + COUNTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
                age[i] <= COUNTER_WIDTH'(NUMBER_OF_CACHE_LINES - 1 - i);
            end
        end else begin
            for (int unsigned i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
                age[i] <= ageNext[i];
            end
        end
    end

    always_comb begin
        replacementCacheLine = '0;
        for (int unsigned i = 0; i < NUMBER_OF_CACHE_LINES; i++) begin
            if (age[i] == MaxAge)
                replacementCacheLine = COUNTER_WIDTH'(i);
        end
    end

endmodule

// File: tb/tb_lru_replacement_algorithm.sv
// Bench for lru_replacement_algorithm: recency-list reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized phase.
module tb_lru_replacement_algorithm;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] lastAccessedCacheLine = '0;
    logic          invalidate = 1'b0;
    logic [CW-1:0] invalidatedCacheLine = '0;
    logic [CW-1:0] replacementCacheLine;

    int errors = 0;
    int checks = 0;
    bit checkOn = 1'b0;

    // Recency list: front is MRU, back is LRU.
    int order[$];

    lru_replacement_algorithm #(
        .NUMBER_OF_CACHE_LINES(N),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .lastAccessedCacheLine(lastAccessedCacheLine),
        .invalidate(invalidate),
        .invalidatedCacheLine(invalidatedCacheLine),
        .replacementCacheLine(replacementCacheLine)
    );

    always #5 clock = ~clock;

    function automatic void modelReset();
        order.delete();
        for (int i = N - 1; i >= 0; i--) order.push_back(i);
    endfunction

    function automatic void modelRemove(input int line);
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == line) begin
                order.delete(i);
                break;
            end
        end
    endfunction

    function automatic void modelApply(input bit en, input int a, input bit inv, input int x);
        if (inv) begin
            if (x < N) begin
                modelRemove(x);
                order.push_back(x);
            end
        end else if (en && a < N) begin
            modelRemove(a);
            order.push_front(a);
        end
    endfunction

    function automatic int modelLru();
        return order[order.size() - 1];
    endfunction

    function automatic void check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    always @(negedge clock) begin
        if (checkOn && !reset)
            check("modelCompare", int'(replacementCacheLine), modelLru());
    end

    task automatic step(input bit en, input int a, input bit inv, input int x);
        @(negedge clock);
        enable = en;
        lastAccessedCacheLine = CW'(a);
        invalidate = inv;
        invalidatedCacheLine = CW'(x);
        @(posedge clock);
        modelApply(en, a, inv, x);
        #1;
        enable = 1'b0;
        invalidate = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        modelReset();
        #1;
        check("asyncReset", int'(replacementCacheLine), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] held;

        // Reset without any clock edge.
        #1 reset = 1'b1;
        modelReset();
        #1 check("resetNoClock", int'(replacementCacheLine), 0);
        @(negedge clock);
        reset = 1'b0;
        checkOn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1 check("idleAfterReset", int'(replacementCacheLine), 0);
        end

        // LRU rotation.
        doReset();
        step(1, 0, 0, 0); check("access0", int'(replacementCacheLine), 1);
        step(1, 1, 0, 0); check("access1", int'(replacementCacheLine), 2);
        step(1, 2, 0, 0); check("access2", int'(replacementCacheLine), 3);
        step(1, 3, 0, 0); check("access3", int'(replacementCacheLine), 0);

        // Accessing non-LRU lines keeps line 0 as victim; MRU re-access is a no-op.
        doReset();
        step(1, 1, 0, 0); check("seq1", int'(replacementCacheLine), 0);
        step(1, 2, 0, 0); check("seq2", int'(replacementCacheLine), 0);
        step(1, 3, 0, 0); check("seq3", int'(replacementCacheLine), 0);
        step(1, 3, 0, 0); check("mruReaccess", int'(replacementCacheLine), 0);
        step(1, 0, 0, 0); check("afterMru", int'(replacementCacheLine), 1);

        // Invalidate and its priority over a simultaneous access.
        doReset();
        step(0, 0, 1, 2); check("invalidate2", int'(replacementCacheLine), 2);
        step(1, 1, 1, 2); check("invPriority", int'(replacementCacheLine), 2);
        step(1, 2, 1, 3); check("invOverAccess", int'(replacementCacheLine), 3);
        step(0, 0, 1, 3); check("invLruNoop", int'(replacementCacheLine), 3);

        // Idle with toggling index.
        held = replacementCacheLine;
        for (int i = 0; i < 10; i++) begin
            step(0, int'($urandom_range(0, N - 1)), 0, int'($urandom_range(0, N - 1)));
            check("idleHold", int'(replacementCacheLine), int'(held));
        end

        // Mid-sequence asynchronous reset.
        doReset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0); check("preMidReset", int'(replacementCacheLine), 2);
        #2 reset = 1'b1;
        modelReset();
        #1 check("midReset", int'(replacementCacheLine), 0);
        @(negedge clock);
        reset = 1'b0;
        step(1, 0, 0, 0); check("postMidReset", int'(replacementCacheLine), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)));
        end

        @(negedge clock);
        #1;
        checkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
